// File: rtl/hwpe_ctrl_package.sv
// hwpe_ctrl_package
// Shared types and default sizes for the HWPE control slice.
//   ctx_sched_state_e : job-context scheduler FSM states
//   ctx_sched_flags_t : status flags exported by the job-context scheduler
package hwpe_ctrl_package;

    // Default register-file dimensions.
    localparam int unsigned REGFILE_N_MAX_CORES = 16;
    localparam int unsigned REGFILE_N_CONTEXT   = 2;
    localparam int unsigned REGFILE_N_EVT       = 2;

    // Width of a context id for the default number of contexts.
    localparam int unsigned CTX_SCHED_ID_W = $clog2(REGFILE_N_CONTEXT);

    // Event indices within a core's event vector.
    localparam int unsigned EVT_JOB_DONE  = 0;
    localparam int unsigned EVT_CTX_AVAIL = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FREE  = 2'd3
    } ctx_sched_state_e;

    typedef struct packed {
        logic                      is_working;
        logic [CTX_SCHED_ID_W-1:0] running_ctx;
        logic [CTX_SCHED_ID_W-1:0] pointer_ctx;
        logic                      full;
    } ctx_sched_flags_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// hwpe_ctrl_ctx_scheduler
// Job-context scheduler between the HWPE register front-end and the engine.
// Cores acquire a register context, fill it and trigger it. Triggered contexts
// are run on the engine in ring order. Each completion pulses the owner's
// job-done event, frees the context and wakes every core that was denied a
// context since the previous completion.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   acquire_req_i     one-cycle context request from core acquire_core_i
//   acquire_gnt_o     combinational grant for that request
//   acquire_id_o      context id handed out on grant
//   trigger_i         commit the currently acquired context
//   start_o / done_i  engine start pulse / engine done pulse
//   evt_o             per-core event pulses [core][event]
//   is_working_o      engine busy
//   running_ctx_o     context currently used by the engine
//   pointer_ctx_o     next context to hand out
//   full_o            every context is occupied
//   finished_o        jobs completed since reset
module hwpe_ctrl_ctx_scheduler
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CORES   = REGFILE_N_MAX_CORES,
    parameter int unsigned N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int unsigned N_EVT     = REGFILE_N_EVT,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            acquire_req_i,
    input  logic [$clog2(N_CORES)-1:0]      acquire_core_i,
    output logic                            acquire_gnt_o,
    output logic [$clog2(N_CONTEXT)-1:0]    acquire_id_o,
    input  logic                            trigger_i,
    output logic                            start_o,
    input  logic                            done_i,
    output logic [N_CORES-1:0][N_EVT-1:0]   evt_o,
    output logic                            is_working_o,
    output logic [$clog2(N_CONTEXT)-1:0]    running_ctx_o,
    output logic [$clog2(N_CONTEXT)-1:0]    pointer_ctx_o,
    output logic                            full_o,
    output logic [CNT_W-1:0]                finished_o
);

    localparam int unsigned ID_W   = $clog2(N_CONTEXT);
    localparam int unsigned CORE_W = $clog2(N_CORES);
    localparam int unsigned OCC_W  = ID_W + 1;

    ctx_sched_state_e  state_q, state_d;
    ctx_sched_flags_t  flags;

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   run_ptr_q;
    logic [ID_W-1:0]   running_ctx_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  pend_q;
    logic              lock_q;
    logic [N_CORES-1:0] waiter_q;
    logic [CORE_W-1:0] owner_q [N_CONTEXT];
    logic [CNT_W-1:0]  finished_q;

    logic full;
    logic grant;
    logic deny;
    logic trig_fire;
    logic in_start;
    logic in_free;
    logic job_ready;

    // Grant decisions look only at registered occupancy, so a context freed
    // in this cycle becomes grantable one cycle later.
    assign full      = (occ_q == OCC_W'(N_CONTEXT));
    assign grant     = acquire_req_i & ~lock_q & ~full;
    assign deny      = acquire_req_i & ~grant;
    assign trig_fire = trigger_i & lock_q;
    assign in_start  = (state_q == START);
    assign in_free   = (state_q == FREE);

    // A trigger in this cycle counts as pending so an idle engine starts
    // on the very next cycle.
    assign job_ready = (pend_q != '0) | trig_fire;

    // Next-state logic of the engine sequencing FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (job_ready) state_d = START;
            START:   state_d = RUN;
            RUN:     if (done_i) state_d = FREE;
            FREE:    state_d = job_ready ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion and wake-up events are emitted only during the FREE cycle.
    always_comb begin
        evt_o = '0;
        if (in_free) begin
            evt_o[owner_q[run_ptr_q]][EVT_JOB_DONE] = 1'b1;
            for (int k = 0; k < N_CORES; k++) begin
                evt_o[k][EVT_CTX_AVAIL] = waiter_q[k];
            end
        end
    end

    // All scheduler state; the pending count moves up on a trigger and down
    // when the engine picks a context, both possibly in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            run_ptr_q     <= '0;
            running_ctx_q <= '0;
            occ_q         <= '0;
            pend_q        <= '0;
            lock_q        <= 1'b0;
            waiter_q      <= '0;
            finished_q    <= '0;
            for (int i = 0; i < N_CONTEXT; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_q + OCC_W'(grant) - OCC_W'(in_free);
            pend_q   <= pend_q + OCC_W'(trig_fire) - OCC_W'(in_start);
            waiter_q <= (in_free ? '0 : waiter_q) |
                        (deny ? (N_CORES'(1) << acquire_core_i) : '0);
            if (grant) begin
                lock_q         <= 1'b1;
                owner_q[ptr_q] <= acquire_core_i;
            end else if (trig_fire) begin
                lock_q <= 1'b0;
                ptr_q  <= ptr_q + ID_W'(1);
            end
            if (in_start) begin
                running_ctx_q <= run_ptr_q;
            end
            if (in_free) begin
                run_ptr_q  <= run_ptr_q + ID_W'(1);
                finished_q <= finished_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        flags             = '0;
        flags.is_working  = (state_q == START) | (state_q == RUN);
        flags.running_ctx = CTX_SCHED_ID_W'(running_ctx_q);
        flags.pointer_ctx = CTX_SCHED_ID_W'(ptr_q);
        flags.full        = full;
    end

    assign acquire_gnt_o = grant;
    assign acquire_id_o  = ID_W'(flags.pointer_ctx);
    assign pointer_ctx_o = ID_W'(flags.pointer_ctx);
    assign running_ctx_o = ID_W'(flags.running_ctx);
    assign is_working_o  = flags.is_working;
    assign full_o        = flags.full;
    assign start_o       = in_start;
    assign finished_o    = finished_q;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// tb_hwpe_ctrl_ctx_scheduler
// Directed bench for the job-context scheduler. Stimulus pushes expected
// start pulses and event vectors into queues; a monitor pops and compares
// them whenever the scheduler presents start_o or a non-zero evt_o.
module tb_hwpe_ctrl_ctx_scheduler;

    localparam int N_CORES   = 16;
    localparam int N_CONTEXT = 2;
    localparam int N_EVT     = 2;
    localparam int CNT_W     = 32;

    typedef logic [N_CORES-1:0][N_EVT-1:0] evt_t;
    typedef struct {
        int   cyc;
        int   ctx;
        evt_t evt;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic                         acquire_req;
    logic [$clog2(N_CORES)-1:0]   acquire_core;
    logic                         acquire_gnt;
    logic [$clog2(N_CONTEXT)-1:0] acquire_id;
    logic                         trigger;
    logic                         start;
    logic                         done;
    evt_t                         evt;
    logic                         is_working;
    logic [$clog2(N_CONTEXT)-1:0] running_ctx;
    logic [$clog2(N_CONTEXT)-1:0] pointer_ctx;
    logic                         full;
    logic [CNT_W-1:0]             finished;

    exp_t startQ[$];
    exp_t evtQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chkRun = 0;
    int   expRun = 0;

    hwpe_ctrl_ctx_scheduler #(
        .N_CORES  (N_CORES),
        .N_CONTEXT(N_CONTEXT),
        .N_EVT    (N_EVT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .acquire_req_i (acquire_req),
        .acquire_core_i(acquire_core),
        .acquire_gnt_o (acquire_gnt),
        .acquire_id_o  (acquire_id),
        .trigger_i     (trigger),
        .start_o       (start),
        .done_i        (done),
        .evt_o         (evt),
        .is_working_o  (is_working),
        .running_ctx_o (running_ctx),
        .pointer_ctx_o (pointer_ctx),
        .full_o        (full),
        .finished_o    (finished)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Drives one cycle of inputs starting just after a rising edge; when a
    // request is issued the combinational grant is checked mid-cycle.
    task automatic applyStimulus(input bit req, input int core, input bit trig, input bit dn,
                                 input bit expGnt, input int expId);
        acquire_req  = req;
        acquire_core = core[$clog2(N_CORES)-1:0];
        trigger      = trig;
        done         = dn;
        if (req) begin
            @(negedge clk);
            checkOutput("acquire_gnt", 64'(acquire_gnt), 64'(expGnt));
            if (expGnt) checkOutput("acquire_id", 64'(acquire_id), 64'(expId));
        end
        @(posedge clk);
        #1;
        acquire_req = 1'b0;
        trigger     = 1'b0;
        done        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic pushStart(input int c, input int ctx);
        exp_t e;
        e.cyc = c;
        e.ctx = ctx;
        e.evt = '0;
        startQ.push_back(e);
    endtask

    task automatic pushEvt(input int c, input evt_t v);
        exp_t e;
        e.cyc = c;
        e.ctx = 0;
        e.evt = v;
        evtQ.push_back(e);
    endtask

    // Monitor: every start pulse and every event vector must match the next
    // queued expectation, and the running context is checked one cycle later.
    always @(negedge clk) begin
        if (!rst) begin
            if (chkRun) begin
                chkRun = 0;
                checkOutput("running_ctx", 64'(running_ctx), 64'(expRun));
            end
            if (start) begin
                if (startQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected start_o: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    monE = startQ.pop_front();
                    checkOutput("start_o cycle", 64'(cyc), 64'(monE.cyc));
                    chkRun = 1;
                    expRun = monE.ctx;
                end
            end
            if (evt != '0) begin
                if (evtQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected evt_o: got %0h at cycle %0d, expected none", evt, cyc);
                end else begin
                    monE = evtQ.pop_front();
                    checkOutput("evt_o cycle", 64'(cyc), 64'(monE.cyc));
                    checkOutput("evt_o value", 64'(evt), 64'(monE.evt));
                end
            end
        end
    end

    initial begin
        int   t;
        int   u;
        evt_t ev;

        rst          = 1'b1;
        acquire_req  = 1'b0;
        acquire_core = '0;
        trigger      = 1'b0;
        done         = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("reset start_o", 64'(start), 64'd0);
        checkOutput("reset evt_o", 64'(evt), 64'd0);
        checkOutput("reset is_working", 64'(is_working), 64'd0);
        checkOutput("reset pointer_ctx", 64'(pointer_ctx), 64'd0);
        checkOutput("reset full", 64'(full), 64'd0);
        checkOutput("reset finished", 64'(finished), 64'd0);

        $display("[TB] single job on core 3");
        applyStimulus(1, 3, 0, 0, 1, 0);
        t = cyc;
        pushStart(t + 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idle(2);
        u = cyc;
        ev = '0;
        ev[3][0] = 1'b1;
        pushEvt(u + 1, ev);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(2);
        checkOutput("single finished", 64'(finished), 64'd1);
        checkOutput("single pointer_ctx", 64'(pointer_ctx), 64'd1);
        checkOutput("single is_working", 64'(is_working), 64'd0);

        $display("[TB] fill, denied acquire and back-to-back");
        applyStimulus(1, 1, 0, 0, 1, 1);
        t = cyc;
        pushStart(t + 1, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("fill full", 64'(full), 64'd1);
        applyStimulus(1, 5, 0, 0, 0, 0);
        u = cyc;
        ev = '0;
        ev[1][0] = 1'b1;
        ev[5][1] = 1'b1;
        pushEvt(u + 1, ev);
        pushStart(u + 2, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(3);
        u = cyc;
        ev = '0;
        ev[2][0] = 1'b1;
        pushEvt(u + 1, ev);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(2);
        checkOutput("fill finished", 64'(finished), 64'd3);
        checkOutput("fill full after drain", 64'(full), 64'd0);
        checkOutput("fill pointer_ctx", 64'(pointer_ctx), 64'd1);

        $display("[TB] trigger without acquire, done while idle");
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(3);
        checkOutput("illegal finished", 64'(finished), 64'd3);
        checkOutput("illegal pointer_ctx", 64'(pointer_ctx), 64'd1);
        checkOutput("illegal is_working", 64'(is_working), 64'd0);

        $display("[TB] reset while running");
        applyStimulus(1, 7, 0, 0, 1, 1);
        t = cyc;
        pushStart(t + 1, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("midrst start_o", 64'(start), 64'd0);
        checkOutput("midrst evt_o", 64'(evt), 64'd0);
        checkOutput("midrst is_working", 64'(is_working), 64'd0);
        checkOutput("midrst running_ctx", 64'(running_ctx), 64'd0);
        checkOutput("midrst pointer_ctx", 64'(pointer_ctx), 64'd0);
        checkOutput("midrst finished", 64'(finished), 64'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(3);
        checkOutput("midrst finished after done", 64'(finished), 64'd0);

        $display("[TB] five sequential jobs wrap the ring");
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1, j, 0, 0, 1, j % 2);
            t = cyc;
            pushStart(t + 1, j % 2);
            applyStimulus(0, 0, 1, 0, 0, 0);
            idle(2);
            u = cyc;
            ev = '0;
            ev[j][0] = 1'b1;
            pushEvt(u + 1, ev);
            applyStimulus(0, 0, 0, 1, 0, 0);
            idle(2);
        end
        checkOutput("wrap finished", 64'(finished), 64'd5);
        checkOutput("wrap pointer_ctx", 64'(pointer_ctx), 64'd1);

        idle(3);
        checkOutput("start queue drained", 64'(startQ.size()), 64'd0);
        checkOutput("event queue drained", 64'(evtQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
